// File: rtl/register_pkg.sv
// Shared definitions for the register bank load controller: FSM encoding,
// default bus geometry and the width of the retry counter.
package register_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int RETRY_W      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    READ   = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/idx_onehot_dec.sv
// Index to one-hot decoder with enable; indices at or beyond NUM_REGS
// decode to all zeros so no register is ever strobed for a bad index.
module idx_onehot_dec #(
  parameter int IDX_W    = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (32'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_loader.sv
// Command-driven write-verify / read controller for a bank of registers
// sharing one data_in bus, with bounded reload retries and a status response.
module register_loader
  import register_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int IDX_W     = 3,
  parameter int MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [IDX_W-1:0]           cmd_idx,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic [DATA_W-1:0]          data_in,
  output logic [NUM_REGS-1:0]        load,
  input  logic [NUM_REGS*DATA_W-1:0] rd_bus,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic [RETRY_W-1:0]         rsp_retries
);

  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    din_d;
  logic [DATA_W-1:0]    rdata_d;
  logic                 err_d;
  logic [RETRY_W-1:0]   retries_d;
  logic [DATA_W-1:0]    observed;
  logic                 in_range;
  logic                 load_en;

  // Loop-based select keeps the slice legal even if idx_q holds a value
  // beyond the populated registers.
  function automatic logic [DATA_W-1:0] slice_at(
    input logic [NUM_REGS*DATA_W-1:0] bus,
    input logic [IDX_W-1:0]           idx
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) begin
        v = bus[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  assign observed  = slice_at(rd_bus, idx_q);
  assign in_range  = ({1'b0, cmd_idx} < NUM_REGS_L);
  assign cmd_ready = reset && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign load_en   = reset && (state == LOAD);

  idx_onehot_dec #(
    .IDX_W   (IDX_W),
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .en    (load_en),
    .idx   (idx_q),
    .onehot(load)
  );

  always_comb begin
    state_d   = state;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    din_d     = data_in;
    rdata_d   = rsp_data;
    err_d     = rsp_err;
    retries_d = rsp_retries;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          idx_d     = cmd_idx;
          wdata_d   = cmd_data;
          retries_d = '0;
          if (!in_range) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (cmd_write) begin
            din_d   = cmd_data;
            state_d = LOAD;
          end else begin
            state_d = READ;
          end
        end
      end
      LOAD: begin
        state_d = VERIFY;
      end
      VERIFY: begin
        if (observed == wdata_q) begin
          rdata_d = wdata_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (32'(rsp_retries) < MAX_RETRY) begin
          retries_d = rsp_retries + RETRY_W'(1);
          state_d   = LOAD;
        end else begin
          rdata_d = observed;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      READ: begin
        rdata_d = observed;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      data_in     <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
    end else begin
      state       <= state_d;
      data_in     <= din_d;
      rsp_data    <= rdata_d;
      rsp_err     <= err_d;
      rsp_retries <= retries_d;
    end
  end

  // Captured command fields carry no meaning until a command is accepted.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_register_loader.sv
// Bench for register_loader: behavioural register bank on the bus, a
// command-level reference model, and one task per scenario.
module tb_register_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_idx;
  logic [7:0]  cmd_data;
  logic [7:0]  data_in;
  logic [7:0]  load;
  logic [63:0] rd_bus;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_retries;

  logic        cmd_valid6, cmd_ready6, cmd_write6;
  logic [2:0]  cmd_idx6;
  logic [7:0]  cmd_data6, data_in6, rsp_data6;
  logic [5:0]  load6;
  logic [47:0] rd_bus6;
  logic        rsp_valid6, rsp_ready6, rsp_err6;
  logic [1:0]  rsp_retries6;

  int checks = 0;
  int failures = 0;

  logic [7:0] regs [8];
  logic [7:0] exp_reg [8];
  logic [7:0] stuck_mask = 8'h00;
  logic       clr = 1'b0;
  logic       pre_en = 1'b0;
  logic [2:0] pre_idx = 3'd0;
  logic [7:0] pre_val = 8'h00;
  logic [7:0] exp_load = 8'h00;
  logic [7:0] exp_din = 8'h00;
  int         load_cnt = 0;
  int         load_bad = 0;
  int         load6_cnt = 0;

  always #5 clk = ~clk;

  register_loader #(.DATA_W(8), .NUM_REGS(8), .IDX_W(3), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .data_in(data_in), .load(load), .rd_bus(rd_bus), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_retries(rsp_retries)
  );

  register_loader #(.DATA_W(8), .NUM_REGS(6), .IDX_W(3), .MAX_RETRY(2)) dut6 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
    .cmd_write(cmd_write6), .cmd_idx(cmd_idx6), .cmd_data(cmd_data6),
    .data_in(data_in6), .load(load6), .rd_bus(rd_bus6), .rsp_valid(rsp_valid6),
    .rsp_ready(rsp_ready6), .rsp_data(rsp_data6), .rsp_err(rsp_err6),
    .rsp_retries(rsp_retries6)
  );

  assign rd_bus6 = {6{8'hC3}};

  // Behavioural registers: capture data_in on their load bit unless stuck.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (clr) regs[i] <= 8'h00;
      else if (pre_en && pre_idx == 3'(i)) regs[i] <= pre_val;
      else if (load[i] && !stuck_mask[i]) regs[i] <= data_in;
    end
  end

  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < 8; i++) rd_bus[i*8 +: 8] = regs[i];
  end

  always @(negedge clk) begin
    if (load !== 8'h00) begin
      load_cnt <= load_cnt + 1;
      if (load !== exp_load || data_in !== exp_din) load_bad <= load_bad + 1;
    end
    if (load6 !== 6'h00) load6_cnt <= load6_cnt + 1;
  end

  // Reference model: outcome of a command from register contents alone.
  function automatic void model_cmd(input logic w, input logic [2:0] idx, input logic [7:0] d,
                                    output logic [7:0] rd, output logic er, output logic [1:0] rt,
                                    output int lat, output int nl);
    logic [7:0] obs;
    if (w) begin
      obs = stuck_mask[idx] ? exp_reg[idx] : d;
      if (!stuck_mask[idx]) exp_reg[idx] = d;
      if (obs == d) begin rd = d; er = 1'b0; rt = 2'd0; lat = 3; nl = 1; end
      else begin rd = obs; er = 1'b1; rt = 2'd2; lat = 3 + 2 * 2; nl = 3; end
    end else begin
      rd = exp_reg[idx]; er = 1'b0; rt = 2'd0; lat = 2; nl = 0;
    end
  endfunction

  task automatic preload(input logic [2:0] idx, input logic [7:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
    exp_reg[idx] = val;
  endtask

  task automatic run_cmd(input logic w, input logic [2:0] idx, input logic [7:0] d, input int hold,
                         output logic [7:0] rd, output logic er, output logic [1:0] rt,
                         output int lat, output int nl, output logic hold_ok);
    int g;
    int base;
    exp_load = 8'(1) << idx;
    exp_din  = d;
    @(negedge clk);
    g = 0;
    while (cmd_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    cmd_valid = 1'b1; cmd_write = w; cmd_idx = idx; cmd_data = d;
    base = load_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid !== 1'b1 && lat < 40);
    rd = rsp_data; er = rsp_err; rt = rsp_retries; hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_err !== er || rsp_retries !== rt ||
          cmd_ready !== 1'b0 || load !== 8'h00) hold_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    nl = load_cnt - base;
  endtask

  task automatic test_reset;
    reset = 1'b0; clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_reg[i] = 8'h00;
    checks++;
    if (cmd_ready !== 1'b0 || load !== 8'h00 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold cmd_ready=%b load=%h rsp_valid=%b required 0/00/0", cmd_ready, load, rsp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, data_in, rsp_data, rsp_err, rsp_retries, load} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values cmd_ready=%b rsp_valid=%b data_in=%h rsp_data=%h err=%b rt=%0d load=%h",
               cmd_ready, rsp_valid, data_in, rsp_data, rsp_err, rsp_retries, load);
    end
  endtask

  task automatic exec_and_compare(input string name, input logic w, input logic [2:0] idx,
                                  input logic [7:0] d, input int hold, output logic hold_ok);
    logic [7:0] rd, erd; logic er, eer; logic [1:0] rt, ert; int lat, elat, nl, enl;
    model_cmd(w, idx, d, erd, eer, ert, elat, enl);
    run_cmd(w, idx, d, hold, rd, er, rt, lat, nl, hold_ok);
    checks++;
    if ({rd, er, rt, 8'(lat), 4'(nl)} !== {erd, eer, ert, 8'(elat), 4'(enl)}) begin
      failures++;
      $display("FAIL %s rd=%h err=%b rt=%0d lat=%0d loads=%0d required rd=%h err=%b rt=%0d lat=%0d loads=%0d",
               name, rd, er, rt, lat, nl, erd, eer, ert, elat, enl);
    end
  endtask

  task automatic test_write;
    logic h;
    exec_and_compare("write_idx3", 1'b1, 3'd3, 8'hA5, 0, h);
  endtask

  task automatic test_read;
    logic h;
    preload(3'd5, 8'h3C);
    exec_and_compare("read_idx5", 1'b0, 3'd5, 8'h00, 0, h);
  endtask

  task automatic test_stuck;
    logic h;
    preload(3'd0, 8'h00);
    stuck_mask = 8'h01;
    exec_and_compare("stuck_write", 1'b1, 3'd0, 8'hFF, 0, h);
    stuck_mask = 8'h00;
  endtask

  task automatic test_hold;
    logic h;
    exec_and_compare("hold_write", 1'b1, 3'd2, 8'($urandom_range(255)), 5, h);
    checks++;
    if (h !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable observed=%b required=1", h);
    end
    exec_and_compare("after_hold_read", 1'b0, 3'd2, 8'h00, 0, h);
  endtask

  task automatic test_reset_mid;
    logic h;
    int seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_idx = 3'd4; cmd_data = 8'h77;
    exp_load = 8'h10; exp_din = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_reg[4] = 8'h77;
    #1;
    checks++;
    if (load !== 8'h00) begin failures++; $display("FAIL reset_verify_load load=%h required=00", load); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_verify_next rsp_valid=%b cmd_ready=%b required 0/0", rsp_valid, cmd_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready cmd_ready=%b required=1", cmd_ready); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL dropped_rsp responses=%0d required=0", seen); end
    // Reset landing in the LOAD cycle must suppress the strobe itself.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_idx = 3'd6; cmd_data = 8'h99;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (load !== 8'h00) begin failures++; $display("FAIL reset_load_forced load=%h required=00", load); end
    @(negedge clk);
    reset = 1'b1;
    exec_and_compare("read_after_drop", 1'b0, 3'd6, 8'h00, 0, h);
  endtask

  task automatic test_back_to_back;
    int cyc, acc0, acc1, nacc, nrsp, g;
    logic [7:0] r0, r1; logic e0, e1;
    acc0 = 0; acc1 = 0; r0 = 8'h00; r1 = 8'h00; e0 = 1'b1; e1 = 1'b1;
    @(negedge clk);
    g = 0;
    while (cmd_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_idx = 3'd7; cmd_data = 8'h5A;
    exp_load = 8'h80; exp_din = 8'h5A;
    exp_reg[7] = 8'h5A;
    cyc = 0; nacc = 0; nrsp = 0;
    while (nrsp < 2 && cyc < 30) begin
      if (rsp_valid === 1'b1) begin
        if (nrsp == 0) begin r0 = rsp_data; e0 = rsp_err; end
        else begin r1 = rsp_data; e1 = rsp_err; end
        nrsp++;
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        if (nacc == 0) acc0 = cyc; else acc1 = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (nacc == 1) cmd_write = 1'b0;
      if (nacc >= 2) cmd_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if ({r0, e0, r1, e1, 8'(acc1 - acc0)} !== {8'h5A, 1'b0, exp_reg[7], 1'b0, 8'd4}) begin
      failures++;
      $display("FAIL back_to_back wr=%h/%b rd=%h/%b spacing=%0d required 5a/0 5a/0 4", r0, e0, r1, e1, acc1 - acc0);
    end
  endtask

  task automatic test_random;
    logic h;
    logic w; logic [2:0] idx; logic [7:0] d;
    stuck_mask = 8'h01;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(1));
      idx = 3'($urandom_range(7));
      d = 8'($urandom_range(255));
      if (n % 10 == 0) d = exp_reg[idx];
      exec_and_compare("random_cmd", w, idx, d, int'($urandom_range(2)), h);
    end
    stuck_mask = 8'h00;
    checks++;
    if (load_bad != 0) begin failures++; $display("FAIL load_strobe_shape bad_cycles=%0d required=0", load_bad); end
  endtask

  task automatic test_out_of_range6;
    logic [7:0] rd; logic er; logic [1:0] rt; int lat, base;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_valid6 = 1'b1; cmd_write6 = (k == 0); cmd_idx6 = (k == 0) ? 3'd7 : 3'd6; cmd_data6 = 8'h33;
      base = load6_cnt;
      @(posedge clk); #1;
      cmd_valid6 = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid6 !== 1'b1 && lat < 40);
      rd = rsp_data6; er = rsp_err6; rt = rsp_retries6;
      rsp_ready6 = 1'b1;
      @(posedge clk); #1;
      rsp_ready6 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd, er, rt, 8'(lat), 8'(load6_cnt - base)} !== {8'h00, 1'b1, 2'd0, 8'd1, 8'd0}) begin
        failures++;
        $display("FAIL oor6_case%0d rd=%h err=%b rt=%0d lat=%0d loads=%0d required 00/1/0/1/0",
                 k, rd, er, rt, lat, load6_cnt - base);
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_idx = 3'd0; cmd_data = 8'h00; rsp_ready = 1'b0;
    cmd_valid6 = 1'b0; cmd_write6 = 1'b0; cmd_idx6 = 3'd0; cmd_data6 = 8'h00; rsp_ready6 = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_stuck();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_out_of_range6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
